vga_fb_arbiter: RTL and testbench

Time-slot arbiter sharing one single-port framebuffer RAM between VGA scanout reads and a drawing client's writes. Runs on CLOCK_50 alongside the VGA timing generator and takes its next_x/next_y as scan coordinates. It returns the scanout pixel, already registered, for the generator's red/green/blue inputs. Writes are accepted through a valid/ready port backed by a 2-entry buffer and retired only in slots not reserved for scanout.

---
 rtl/vga_fb_arbiter_if.sv | 32 +++
 rtl/vga_fb_arbiter.sv | 127 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: scan coordinates, scanout pixel, write request port and RAM port.
// Latency: none, this is only a signal bundle.
// Backpressure: wr_valid/wr_ready handshake. The slave drives wr_ready.
interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 24
);
   logic [9:0]        scan_x;
   logic [9:0]        scan_y;
   logic [DATA_W-1:0] pix_out;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [15:0]       wr_drop_cnt;

   // The timing generator, drawing client and RAM together form the master side.
   modport master (
      output scan_x, scan_y, wr_valid, wr_addr, wr_data, mem_rdata,
      input  pix_out, wr_ready, mem_addr, mem_we, mem_wdata, wr_drop_cnt
   );

   // The arbiter forms the slave side.
   modport slave (
      input  scan_x, scan_y, wr_valid, wr_addr, wr_data, mem_rdata,
      output pix_out, wr_ready, mem_addr, mem_we, mem_wdata, wr_drop_cnt
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: the single-port framebuffer is time-sliced. Even cycles are scanout reads.
// Odd cycles are write slots. Scanout latency is 2 cycles (one pixel clock), and pix_out is registered.
// Backpressure: a 2-entry write FIFO. wr_ready drops when the FIFO is full or reset is held.
// Optional macro VGA_ARB_BLANK_WRITE_EN: read slots that fall in blanking also retire writes.
module vga_fb_arbiter #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19,
   parameter int DATA_W = 24
) (
   input  logic             i_clock_50,
   input  logic             i_reset_n,
   vga_fb_arbiter_if.slave  io_fb
);
   localparam logic [9:0]      LP_H  = 10'(H_RES);
   localparam logic [9:0]      LP_V  = 10'(V_RES);
   localparam logic [ADDR_W:0] LP_FB = (ADDR_W+1)'(H_RES * V_RES);

   logic              r_phase;       // 0: read slot, 1: write slot
   logic [1:0]        r_count;
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [ADDR_W-1:0] r_fifo_addr [2];
   logic [DATA_W-1:0] r_fifo_data [2];
   logic              r_rd_issued;   // the current/preceding read slot issued a RAM read
   logic [DATA_W-1:0] r_pix;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_we;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [15:0]       r_drop_cnt;

   logic              w_scan_active;
   logic [ADDR_W-1:0] w_x;
   logic [ADDR_W-1:0] w_y;
   logic [ADDR_W-1:0] w_scan_addr;
   logic              w_wr_ready;
   logic              w_push;
   logic              w_slot_wr_ok;
   logic              w_pop;
   logic              w_head_ok;

   // Out-of-range coordinates, including wrapped negative offsets, count as blanking.
   assign w_scan_active = (io_fb.scan_x < LP_H) && (io_fb.scan_y < LP_V);
   assign w_x = ADDR_W'(io_fb.scan_x);
   assign w_y = ADDR_W'(io_fb.scan_y);

   generate
      if (H_RES == 640) begin : g_addr_640
         assign w_scan_addr = (w_y << 9) + (w_y << 7) + w_x;
      end else begin : g_addr_mul
         assign w_scan_addr = (w_y * ADDR_W'(H_RES)) + w_x;
      end
   endgenerate

   assign w_wr_ready = (r_count != 2'd2) && i_reset_n;
   assign w_push     = io_fb.wr_valid && w_wr_ready;

   // Decisions are taken at the edge that enters a slot, so r_phase==0 now means the next slot is a write slot.
`ifdef VGA_ARB_BLANK_WRITE_EN
   assign w_slot_wr_ok = ~r_phase | ~w_scan_active;
`else
   assign w_slot_wr_ok = ~r_phase;
`endif

   assign w_pop     = (r_count != 2'd0) && w_slot_wr_ok;
   assign w_head_ok = {1'b0, r_fifo_addr[r_rd_ptr]} < LP_FB;

   // FIFO storage. Only the pointers and count need reset.
   always_ff @(posedge i_clock_50) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= io_fb.wr_addr;
         r_fifo_data[r_wr_ptr] <= io_fb.wr_data;
      end
   end

   // Slot sequencing, FIFO bookkeeping, RAM port and scanout capture.
   always_ff @(posedge i_clock_50) begin
      if (!i_reset_n) begin
         r_phase     <= 1'b0;
         r_count     <= 2'd0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_rd_issued <= 1'b0;
         r_pix       <= '0;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_phase  <= ~r_phase;
         r_mem_we <= 1'b0;
         if (r_phase) begin
            // The write slot ends here. mem_rdata holds the data for the read issued one cycle ago.
            r_pix       <= r_rd_issued ? io_fb.mem_rdata : '0;
            r_rd_issued <= w_scan_active;
            if (w_scan_active) begin
               r_mem_addr <= w_scan_addr;
            end
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
            if (w_head_ok) begin
               r_mem_addr  <= r_fifo_addr[r_rd_ptr];
               r_mem_wdata <= r_fifo_data[r_rd_ptr];
               r_mem_we    <= 1'b1;
            end else if (r_drop_cnt != 16'hFFFF) begin
               r_drop_cnt <= r_drop_cnt + 16'd1;
            end
         end
         if (w_push) begin
            r_wr_ptr <= ~r_wr_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign io_fb.wr_ready    = w_wr_ready;
   assign io_fb.pix_out     = r_pix;
   assign io_fb.mem_addr    = r_mem_addr;
   assign io_fb.mem_we      = r_mem_we;
   assign io_fb.mem_wdata   = r_mem_wdata;
   assign io_fb.wr_drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed and random checks of the arbiter against a queue-based reference model.
// The RAM model returns the read address as data, with 1-cycle latency.
// Writes are stored in an expected-order queue and retired against observed mem_we pulses.
module tb_vga_fb_arbiter;
   localparam int H_RES = 640;
   localparam int V_RES = 480;
   localparam int FB    = H_RES * V_RES;

   typedef struct {
      logic [18:0] a;
      logic [23:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   vga_fb_arbiter_if #(.ADDR_W(19), .DATA_W(24)) fb ();

   vga_fb_arbiter #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(19), .DATA_W(24)) dut (
      .i_clock_50 (clk),
      .i_reset_n  (reset_n),
      .io_fb      (fb)
   );

   always #10 clk = ~clk;

   int  checks = 0;
   int  errors = 0;
   wr_t exp_q[$];
   int  exp_drop = 0;
   int  we_events = 0;
   int  last_we = 0;
   int  prev_we = 0;
   int  cyc = 0;
   logic tb_phase = 1'b0;
   int  acc_n = 0;
   int  stall_at = -1;
   bit  acc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit active(input logic [9:0] x, input logic [9:0] y);
      return (int'(x) < H_RES) && (int'(y) < V_RES);
   endfunction

   function automatic logic [23:0] exp_pix(input logic [9:0] x, input logic [9:0] y);
      return active(x, y) ? 24'(int'(y) * H_RES + int'(x)) : 24'd0;
   endfunction

   // Reference model for an accepted write: in-range writes are retired in order, others are dropped.
   task automatic model_push(input logic [18:0] a, input logic [23:0] d);
      wr_t e;
      if (int'(a) < FB) begin
         e.a = a;
         e.d = d;
         exp_q.push_back(e);
      end else if (exp_drop < 65535) begin
         exp_drop++;
      end
   endtask

   // RAM model: returns the address it was given, one cycle later.
   always @(posedge clk) fb.mem_rdata <= 24'(fb.mem_addr);

   // Slot parity follows VGA_CLK: it is 0 in reset and toggles every cycle.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      tb_phase <= reset_n ? ~tb_phase : 1'b0;
   end

   // Each write pulse must be in an eligible slot and match the oldest outstanding write.
   always @(negedge clk) begin
      if (reset_n && fb.mem_we) begin
         wr_t e;
         we_events++;
         prev_we = last_we;
         last_we = cyc;
`ifdef VGA_ARB_BLANK_WRITE_EN
         check("we_slot", (tb_phase == 1'b1) || !active(fb.scan_x, fb.scan_y), 1);
`else
         check("we_slot", tb_phase, 1);
`endif
         check("we_pending", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("we_addr", fb.mem_addr, e.a);
            check("we_data", fb.mem_wdata, e.d);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns just after the edge that starts a cycle whose slot parity is p.
   task automatic align(input logic p);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         if (tb_phase == p) break;
      end
   endtask

   // Holds wr_valid until the request is accepted, with a bounded wait.
   task automatic push(input logic [18:0] a, input logic [23:0] d);
      bit done;
      done = 0;
      fb.wr_valid = 1'b1;
      fb.wr_addr  = a;
      fb.wr_data  = d;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (fb.wr_ready) begin
            done = 1;
            acc_n++;
            model_push(a, d);
         end else if (stall_at < 0) begin
            stall_at = acc_n;
         end
         @(posedge clk);
         #1;
      end
      fb.wr_valid = 1'b0;
      check("push_accept", done, 1);
   endtask

   task automatic drive_wr();
      if (!fb.wr_valid || acc) begin
         fb.wr_valid = ($urandom_range(0, 2) != 0);
         fb.wr_addr  = ($urandom_range(0, 9) == 0) ? 19'($urandom_range(FB, 524287))
                                                   : 19'($urandom_range(0, FB - 1));
         fb.wr_data  = 24'($urandom);
      end
   endtask

   task automatic sample_acc();
      acc = fb.wr_valid && fb.wr_ready;
      if (acc) model_push(fb.wr_addr, fb.wr_data);
   endtask

   initial begin
      int base;
      logic [9:0]  rx, ry;
      logic [23:0] prev_pix;
      fb.scan_x   = 10'd700;
      fb.scan_y   = 10'd0;
      fb.wr_valid = 1'b0;
      fb.wr_addr  = '0;
      fb.wr_data  = '0;

      // Reset state
      tick(3);
      @(negedge clk);
      check("rst_pix", fb.pix_out, 0);
      check("rst_we", fb.mem_we, 0);
      check("rst_addr", fb.mem_addr, 0);
      check("rst_wdata", fb.mem_wdata, 0);
      check("rst_drop", fb.wr_drop_cnt, 0);
      check("rst_ready", fb.wr_ready, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick(1);
      @(negedge clk);
      check("rel_ready", fb.wr_ready, 1);
      check("rel_pix", fb.pix_out, 0);
      check("rel_we", fb.mem_we, 0);

      // Scanout read at (5,2): address 1285 and 2-cycle latency
      align(1'b1);
      fb.scan_x = 10'd5;
      fb.scan_y = 10'd2;
      @(negedge clk);
      @(negedge clk);
      check("rd_addr", fb.mem_addr, 1285);
      check("rd_we", fb.mem_we, 0);
      check("rd_pix_early", fb.pix_out, 0);
      @(negedge clk);
      check("rd_pix_n1", fb.pix_out, 0);
      @(negedge clk);
      check("rd_pix", fb.pix_out, 1285);

      // Blanking: no read is issued, and mem_addr holds its last value
      align(1'b1);
      fb.scan_x = 10'd700;
      fb.scan_y = 10'd10;
      @(negedge clk);
      @(negedge clk);
      check("blank_addr_hold", fb.mem_addr, 1285);
      check("blank_we", fb.mem_we, 0);
      @(negedge clk);
      @(negedge clk);
      check("blank_pix", fb.pix_out, 0);
      fb.scan_x = 10'd1020;
      tick(4);
      @(negedge clk);
      check("blank_pix_1020", fb.pix_out, 0);

      // Back-to-back write burst while video is active
      fb.scan_x = 10'd100;
      fb.scan_y = 10'd100;
      tick(4);
      base = we_events;
      align(1'b0);
      acc_n = 0;
      stall_at = -1;
      for (int i = 0; i < 4; i++) push(19'(i), 24'($urandom));
      tick(10);
      check("burst_stall_after", stall_at, 2);
      check("burst_we_count", we_events - base, 4);
      check("burst_drained", exp_q.size(), 0);

      // Out-of-range write is dropped, and the next in-range write lands
      base = we_events;
      push(19'd307200, 24'h123456);
      push(19'd307199, 24'hABCDEF);
      tick(8);
      check("drop_cnt", fb.wr_drop_cnt, 1);
      check("drop_we_count", we_events - base, 1);

      // Drop counter saturates
      force dut.r_drop_cnt = 16'hFFFF;
      #1;
      release dut.r_drop_cnt;
      exp_drop = 65535;
      push(19'd400000, 24'h000001);
      tick(8);
      check("drop_sat", fb.wr_drop_cnt, 16'hFFFF);

      // Two buffered writes during blanking: spacing of the retire pulses
      fb.scan_x = 10'd700;
      fb.scan_y = 10'd10;
      tick(4);
      base = we_events;
      align(1'b0);
      push(19'd10, 24'h00AA55);
      push(19'd11, 24'h0055AA);
      tick(8);
      check("blank_we_count", we_events - base, 2);
`ifdef VGA_ARB_BLANK_WRITE_EN
      check("blank_we_gap", last_we - prev_we, 1);
`else
      check("blank_we_gap", last_we - prev_we, 2);
`endif

      // Reset while the buffer is full: nothing is retired afterwards
      fb.scan_x = 10'd100;
      fb.scan_y = 10'd100;
      tick(4);
      align(1'b0);
      push(19'd20, 24'h111111);
      push(19'd21, 24'h222222);
      reset_n = 1'b0;
      exp_q.delete();
      base = we_events;
      tick(1);
      @(negedge clk);
      check("mid_rst_ready", fb.wr_ready, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      exp_drop = 0;
      tick(8);
      check("mid_rst_no_we", we_events - base, 0);
      @(negedge clk);
      check("mid_rst_ready_after", fb.wr_ready, 1);
      check("mid_rst_drop", fb.wr_drop_cnt, 0);

      // Random scan positions and writes
      align(1'b1);
      acc = 0;
      prev_pix = '0;
      for (int i = 0; i < 300; i++) begin
         rx = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, H_RES - 1));
         ry = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, V_RES - 1));
         fb.scan_x = rx;
         fb.scan_y = ry;
         drive_wr();
         @(negedge clk);
         sample_acc();
         @(posedge clk);
         #1;
         drive_wr();
         @(negedge clk);
         sample_acc();
         if (i > 0) check("rnd_pix", fb.pix_out, prev_pix);
         if (active(rx, ry)) check("rnd_rd_addr", fb.mem_addr, 24'(exp_pix(rx, ry)));
         prev_pix = exp_pix(rx, ry);
         @(posedge clk);
         #1;
      end
      fb.wr_valid = 1'b0;
      fb.scan_x = 10'd700;
      tick(12);
      check("rnd_drained", exp_q.size(), 0);
      check("rnd_drop", fb.wr_drop_cnt, exp_drop);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
